// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: FSM states,
// pending control-transfer record and the PC/nPC advance rule.
package fetch_unit_pkg;

    localparam logic [31:0] INST_BYTES = 32'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MEM,
        S_ISSUE,
        S_WAIT_ACK,
        S_ADVANCE
    } fetch_state_t;

    typedef struct packed {
        logic        taken;
        logic        annul;
        logic [31:0] target;
    } ctrl_xfer_t;

    // Returns {pc, npc} after retiring the current instruction.
    function automatic logic [63:0] next_pair(
        input logic [31:0] npc,
        input logic        xfer_vld,
        input ctrl_xfer_t  xfer
    );
        logic [31:0] p;
        logic [31:0] n;
        p = npc;
        n = npc + INST_BYTES;
        if (xfer_vld) begin
            case ({xfer.taken, xfer.annul})
                2'b10: begin
                    p = npc;
                    n = xfer.target;
                end
                2'b11: begin
                    p = xfer.target;
                    n = xfer.target + INST_BYTES;
                end
                2'b01: begin
                    p = npc + INST_BYTES;
                    n = npc + (INST_BYTES << 1);
                end
                default: begin
                    p = npc;
                    n = npc + INST_BYTES;
                end
            endcase
        end
        return {p, n};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_seq.sv
// PC/nPC pair plus the pending control-transfer register; the pair
// moves only on the advance strobe.
module fetch_pc_seq
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        ctrl_valid,
    input  logic        ctrl_taken,
    input  logic        ctrl_annul,
    input  logic [31:0] ctrl_target,
    output logic [31:0] pc,
    output logic [31:0] pc_next
);

    logic        pend_vld_q;
    logic        pend_vld_d;
    ctrl_xfer_t  pend_q;
    ctrl_xfer_t  pend_d;
    ctrl_xfer_t  xfer_in;
    ctrl_xfer_t  xfer_use;
    logic        use_vld;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] npc_q;
    logic [31:0] npc_d;

    always_comb begin
        xfer_in.taken  = ctrl_taken;
        xfer_in.annul  = ctrl_annul;
        xfer_in.target = ctrl_target & ~32'h0000_0003;
        // A report arriving in the advance cycle itself wins.
        use_vld    = ctrl_valid | pend_vld_q;
        xfer_use   = ctrl_valid ? xfer_in : pend_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        pc_d       = pc_q;
        npc_d      = npc_q;
        if (advance) begin
            {pc_d, npc_d} = next_pair(npc_q, use_vld, xfer_use);
            pend_vld_d    = 1'b0;
            pend_d        = '0;
        end else if (ctrl_valid) begin
            pend_vld_d = 1'b1;
            pend_d     = xfer_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            npc_q      <= RESET_PC + INST_BYTES;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            npc_q      <= npc_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
        end
    end

    assign pc      = pc_q;
    assign pc_next = pc_d;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: memory read, decoder handshake and the
// control FSM; PC bookkeeping lives in fetch_pc_seq.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        dec_req,
    output logic [31:0] dec_inst,
    input  logic        dec_ack,
    input  logic        ctrl_valid,
    input  logic        ctrl_taken,
    input  logic        ctrl_annul,
    input  logic [31:0] ctrl_target,
    output logic [31:0] pc
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic         imem_req_q;
    logic         imem_req_d;
    logic         dec_req_q;
    logic         dec_req_d;
    logic [31:0]  imem_addr_q;
    logic [31:0]  imem_addr_d;
    logic [31:0]  dec_inst_q;
    logic [31:0]  dec_inst_d;
    logic [31:0]  pc_next;
    logic         advance;

    fetch_pc_seq #(
        .RESET_PC (RESET_PC)
    ) u_pc_seq (
        .clk         (clk),
        .rst         (rst),
        .advance     (advance),
        .ctrl_valid  (ctrl_valid),
        .ctrl_taken  (ctrl_taken),
        .ctrl_annul  (ctrl_annul),
        .ctrl_target (ctrl_target),
        .pc          (pc),
        .pc_next     (pc_next)
    );

    always_comb begin
        state_d    = state_q;
        advance    = 1'b0;
        dec_inst_d = dec_inst_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                if (imem_rvalid) begin
                    dec_inst_d = imem_rdata;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (dec_ack) state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                advance = 1'b1;
                state_d = enable ? S_FETCH : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Strobes are registered off the next state so they line up
        // exactly with FETCH and ISSUE.
        imem_req_d  = (state_d == S_FETCH);
        dec_req_d   = (state_d == S_ISSUE);
        imem_addr_d = imem_req_d ? pc_next : imem_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            imem_req_q  <= 1'b0;
            dec_req_q   <= 1'b0;
            imem_addr_q <= '0;
            dec_inst_q  <= '0;
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            dec_req_q   <= dec_req_d;
            imem_addr_q <= imem_addr_d;
            dec_inst_q  <= dec_inst_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign dec_req   = dec_req_q;
    assign dec_inst  = dec_inst_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decoder. Maintains the SPARC v8 PC/nPC pair, reads one 32-bit instruction per cycle-sequence from instruction memory, hands it to the decoder with a single-cycle request pulse, and holds it stable until the decoder acknowledges. Applies delayed control transfers (taken branch, annul) reported by execute at the PC-advance point.

## Interface
- RESET_PC, 32'h0000_0000, PC after reset; nPC resets to RESET_PC+4
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- enable  in  1  fetch permitted; sampled only in IDLE
- imem_req  out  1  one-cycle read strobe
- imem_addr  out  32  word address (bits[1:0] always 0), valid with imem_req
- imem_rvalid  in  1  read data valid, ≥1 cycle after imem_req
- imem_rdata  in  32  instruction word
- dec_req  out  1  one-cycle pulse to decoder
- dec_inst  out  32  instruction to decode; stable from dec_req until dec_ack sampled high
- dec_ack  in  1  decoder done, single-cycle
- ctrl_valid  in  1  execute reports a control transfer (one-cycle)
- ctrl_taken  in  1  transfer taken
- ctrl_annul  in  1  annul delay slot
- ctrl_target  in  32  transfer target; bits[1:0] ignored
- pc  out  32  PC of instruction currently held in dec_inst

## Operation
- States: IDLE, FETCH, WAIT_MEM, ISSUE, WAIT_ACK, ADVANCE.
- IDLE: enable=1 → FETCH, else stay.
- FETCH: imem_req=1, imem_addr=pc → WAIT_MEM.
- WAIT_MEM: on imem_rvalid, latch imem_rdata into dec_inst → ISSUE. imem_rvalid in any other state is ignored.
- ISSUE: dec_req=1 for exactly this cycle → WAIT_ACK. dec_req must never be high two consecutive cycles; the decoder re-samples req when it returns idle.
- WAIT_ACK: on dec_ack → ADVANCE.
- ADVANCE: update PC/nPC, clear pending transfer → FETCH if enable, else IDLE.
- Pending transfer register: ctrl_valid in any state stores {taken, annul, target[31:2],2'b00}; a later ctrl_valid before ADVANCE overwrites. ctrl_valid in ADVANCE itself is applied in that same cycle.
- Advance rules (npc = current nPC):
  - no pending: pc←npc, npc←npc+4
  - taken, !annul: pc←npc, npc←target
  - taken, annul: pc←target, npc←target+4
  - !taken, annul: pc←npc+4, npc←npc+8
  - !taken, !annul: same as no pending
- Arithmetic: 32-bit, modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: state IDLE, pc=RESET_PC, npc=RESET_PC+4, dec_inst=0, imem_req=0, imem_addr=0, dec_req=0, pending cleared. rst overrides all other inputs in its cycle.
- rst mid-operation: immediate return to reset values; in-flight imem_rvalid/dec_ack after reset ignored (state not WAIT_*).
- Minimum per instruction with 1-cycle memory and 3-cycle decoder: FETCH(1)+WAIT_MEM(1)+ISSUE(1)+WAIT_ACK(3)+ADVANCE(1) = 7 cycles.
- All outputs registered; imem_req and dec_req are high only in FETCH and ISSUE respectively.
- dec_inst and pc change only in WAIT_MEM (on rvalid) and ADVANCE (pc) respectively.

## Structure
- Shared header decodeType.svh gains: fetch_state_t enum, ctrlXfer struct {taken, annul, target[31:0]}, constant INST_BYTES=4.
- One sub-module natural: fetch_pc_seq — holds pc/npc and pending ctrlXfer, computes next pair from advance strobe; fetch_unit owns the FSM and handshakes.

## Test plan
- Reset, enable=1, memory returns 32'h0100_0000 after 1 cycle, dec_ack 3 cycles after dec_req → imem_addr 0,4,8 on successive fetches; dec_req single-cycle; dec_inst=32'h0100_0000 held until ack.
- Taken branch, no annul, reported while at pc=0x10 (npc=0x14), target 0x100 → next fetch addresses 0x14, 0x100, 0x104.
- Taken with annul at pc=0x10, target 0x200 → next fetch 0x200 (0x14 skipped), then 0x204.
- Not-taken annul at pc=0x20 → next fetch 0x28, then 0x2C.
- rst asserted in WAIT_ACK with dec_ack arriving the following cycle → pc=RESET_PC, state IDLE, no ADVANCE, dec_req stays 0 until refetch.
- Memory latency 5 cycles, two ctrl_valid before ADVANCE (targets 0x40 then 0x80, taken) → npc becomes 0x80; imem_req issued once per instruction.
